// File: rtl/keypad_pkg.sv
// Shared types, constants and helpers for the 4x4 keypad scan controller.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    HELD,
    RELEASE
  } state_e;

  localparam int unsigned ROW_W  = 2;
  localparam int unsigned COL_W  = 2;
  localparam int unsigned CODE_W = ROW_W + COL_W;

  localparam logic [3:0] COL_IDLE = 4'b1111;

  // Row index to active-low one-hot row drive pattern.
  function automatic logic [3:0] row_drive_n(input logic [ROW_W-1:0] idx);
    logic [3:0] pat;
    unique case (idx)
      2'd0:    pat = 4'b1110;
      2'd1:    pat = 4'b1101;
      2'd2:    pat = 4'b1011;
      default: pat = 4'b0111;
    endcase
    return pat;
  endfunction

  // True when exactly one column is pulled low; multi-key patterns are rejected.
  function automatic logic is_pressed(input logic [3:0] col);
    logic [3:0] low;
    low = ~col;
    return (low != 4'd0) && ((low & (low - 4'd1)) == 4'd0);
  endfunction

  // Column index of the single low bit; only meaningful when is_pressed() holds.
  function automatic logic [COL_W-1:0] col_index(input logic [3:0] col);
    logic [COL_W-1:0] idx;
    unique case (col)
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous multi-bit level inputs.
module sync_2ff #(
  parameter int unsigned        WIDTH     = 4,
  parameter logic [WIDTH-1:0]   RESET_VAL = '1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // Metastability filter: two back-to-back capture stages.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/keypad_scan_controller.sv
// 4x4 matrix keypad scanner with press/release debounce, one event per press,
// and a two-digit key history.
module keypad_scan_controller
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DWELL      = 4800,
  parameter int unsigned DEBOUNCE_CYCLES = 960000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] col_n,
  input  logic       clear,
  output logic [3:0] row_n,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic [3:0] digit_new,
  output logic [3:0] digit_old,
  output logic       busy
);

  localparam int unsigned CNT_MAX = (SCAN_DWELL > DEBOUNCE_CYCLES) ? SCAN_DWELL : DEBOUNCE_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX);

  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(SCAN_DWELL - 1);
  localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [3:0] col_s;

  state_e            state_q, state_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [3:0]        col_lat_q, col_lat_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [3:0]        row_n_q, row_n_d;
  logic              key_valid_q, key_valid_d;
  logic [CODE_W-1:0] key_code_q, key_code_d;
  logic [CODE_W-1:0] digit_new_q, digit_new_d;
  logic [CODE_W-1:0] digit_old_q, digit_old_d;
  logic              busy_q, busy_d;
  logic              event_fire;
  logic [ROW_W-1:0]  row_next;

  sync_2ff #(
    .WIDTH     (4),
    .RESET_VAL (COL_IDLE)
  ) u_col_sync (
    .clk   (clk),
    .reset (reset),
    .d     (col_n),
    .q     (col_s)
  );

  assign row_next = row_q + ROW_W'(1);

  // Next-state logic for the scan/debounce/hold/release sequence and history.
  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    col_lat_d   = col_lat_q;
    cnt_d       = cnt_q;
    key_valid_d = 1'b0;
    key_code_d  = key_code_q;
    digit_new_d = digit_new_q;
    digit_old_d = digit_old_q;
    event_fire  = 1'b0;

    unique case (state_q)
      SCAN: begin
        if (cnt_q == DWELL_LAST) begin
          cnt_d = '0;
          if (is_pressed(col_s)) begin
            col_lat_d = col_s;
            state_d   = DEBOUNCE;
          end else begin
            row_d = row_next;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DEBOUNCE: begin
        if (col_s != col_lat_q) begin
          state_d = SCAN;
          row_d   = row_next;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          key_valid_d = 1'b1;
          key_code_d  = {row_q, col_index(col_lat_q)};
          event_fire  = 1'b1;
          state_d     = HELD;
          cnt_d       = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HELD: begin
        // Anything but all-idle keeps us here, including a second key.
        if (col_s == COL_IDLE) begin
          state_d = RELEASE;
          cnt_d   = '0;
        end
      end
      RELEASE: begin
        if (col_s != COL_IDLE) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d = SCAN;
          row_d   = row_next;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = SCAN;
        row_d   = '0;
        cnt_d   = '0;
      end
    endcase

    // A new event wins over clear for digit_new; clear still wipes the old slot.
    if (event_fire) begin
      digit_old_d = clear ? '0 : digit_new_q;
      digit_new_d = key_code_d;
    end else if (clear) begin
      digit_old_d = '0;
      digit_new_d = '0;
    end

    row_n_d = row_drive_n(row_d);
    busy_d  = (state_d != SCAN);
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= SCAN;
      row_q       <= '0;
      col_lat_q   <= COL_IDLE;
      cnt_q       <= '0;
      row_n_q     <= 4'b1110;
      key_valid_q <= 1'b0;
      key_code_q  <= '0;
      digit_new_q <= '0;
      digit_old_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      col_lat_q   <= col_lat_d;
      cnt_q       <= cnt_d;
      row_n_q     <= row_n_d;
      key_valid_q <= key_valid_d;
      key_code_q  <= key_code_d;
      digit_new_q <= digit_new_d;
      digit_old_q <= digit_old_d;
      busy_q      <= busy_d;
    end
  end

  assign row_n     = row_n_q;
  assign key_valid = key_valid_q;
  assign key_code  = key_code_q;
  assign digit_new = digit_new_q;
  assign digit_old = digit_old_q;
  assign busy      = busy_q;

endmodule

// File: doc/keypad_scan_controller.md
Name: keypad_scan_controller

Overview:
Sequences the 4x4 matrix keypad. It drives rows one at a time with a programmable dwell and samples the synchronized columns. A candidate key is debounced and the controller then holds on it until release, so each physical press emits exactly one key event. Events feed the hex decoder and a two-digit history register that drives the dual seven-segment display path.

Parameters:
SCAN_DWELL, 4800, clock cycles each row is driven per scan step (100 us at 48 MHz); legal values are 4 or more.
DEBOUNCE_CYCLES, 960000, clock cycles a press or release must be stable (20 ms at 48 MHz); legal values are 2 or more.

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
col_n  input  4  raw keypad columns, active-low with pull-ups, asynchronous to clk
clear  input  1  synchronous clear of the digit history
row_n  output  4  row drive, active-low, one-hot-low
key_valid  output  1  one-cycle pulse marking a new debounced press
key_code  output  4  raw key index {row[1:0], col[1:0]}, held until the next event
digit_new  output  4  most recent key_code
digit_old  output  4  previous key_code
busy  output  1  high in any state other than SCAN

Behaviour:
- Reset values: row_n=4'b1110, key_valid=0, key_code=0, digit_new=0, digit_old=0, busy=0. The FSM is in SCAN with row index 0 and all counters 0. Synchronizer flops reset to 4'b1111.
- col_n passes through a 2-flop synchronizer; the result is col_s. Define pressed(col_s) as exactly one bit of col_s low. All-high means idle. Two or more bits low means an invalid pattern, treated as not pressed.
- SCAN:
  - Drive row_n low on row index r for SCAN_DWELL cycles.
  - On the last dwell cycle, if pressed(col_s): latch r and the col index, clear the counter, go to DEBOUNCE. row_n stays on row r.
  - Otherwise advance r with wrap 3→0 and reload the dwell.
- DEBOUNCE:
  - Each cycle, compare col_s with the latched pattern. On any mismatch, return to SCAN at row (r+1) mod 4 with no event.
  - After DEBOUNCE_CYCLES consecutive matching cycles, on the next clock:
    - key_valid=1 for exactly one cycle;
    - key_code={r, c};
    - digit_old<=digit_new and digit_new<=key_code;
    - go to HELD.
- HELD:
  - row_n stays on row r.
  - When col_s becomes all-high, clear the counter and go to RELEASE.
  - A second key pressed meanwhile (invalid pattern) is ignored and produces no event.
- RELEASE:
  - If any col_s bit goes low, return to HELD with no event.
  - After DEBOUNCE_CYCLES consecutive idle cycles, go to SCAN at row (r+1) mod 4.
- Priority: if clear and a key_valid update happen in the same cycle, the digits get digit_old=0 and digit_new=new code; clear zeros only the old history. clear alone zeroes both digits and leaves key_code unchanged.
- Reset asserted mid-debounce or mid-hold: state returns to the reset values immediately and no event is emitted. Releasing reset resumes scanning from row 0.
- Counters are sized with $clog2 of the larger parameter and saturate-free: they reload on every state change.
- A key held indefinitely produces no repeat events.

Decomposition:
- Shared package keypad_pkg holds:
  - the state enum {SCAN, DEBOUNCE, HELD, RELEASE};
  - COL_IDLE=4'b1111;
  - the row one-hot-low lookup (index → row_n pattern);
  - the key_code field widths.
- Natural sub-module: sync_2ff, a parameterized-width 2-flop synchronizer with async active-high reset to a parameterized value. It is instantiated for col_n.

Test Plan:
Run all scenarios with SCAN_DWELL=4, DEBOUNCE_CYCLES=8.
1. No key (col_n=4'b1111) for 64 cycles → row_n cycles 1110,1101,1011,0111, each for 4 cycles; key_valid never high; busy=0.
2. Hold the key at row 2/col 1 (col_n=4'b1101 while row_n=4'b1011) for 40 cycles, then release → exactly one key_valid pulse with key_code=4'h9; digit_new=9. Scanning resumes at row 3 only after 8 idle cycles.
3. Bounce: assert that key for 3 cycles, release for 1, then assert steadily → no pulse from the first burst; one pulse after the stable press; key_code=4'h9.
4. Two sequential presses, row 0/col 0 then row 3/col 3 → key_code 0 then F; after the second, digit_old=0 and digit_new=F.
5. Press row 1/col 2 and add col 0 during HELD, then release both → exactly one event, key_code=4'h6; the second key produces no event.
6. Assert reset during DEBOUNCE on the 5th counting cycle → immediately row_n=1110 and busy=0, with no key_valid. Apply clear after a press → digit_new=digit_old=0 while key_code is retained.
